// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer. Each entry has a 2-bit saturating
//   direction counter. The fetch-stage lookup is combinational. The
//   execute-stage update, which resolves branches and keeps statistics,
//   happens on the rising clock edge.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   PCF            fetch PC to look up
//   PredTakenF     predicted taken for PCF
//   PredTargetF    predicted next PC (PCF+4 when not predicted taken)
//   StallE         EX stage stalled; blocks update and statistics
//   BranchValidE   EX holds a conditional branch
//   PCE            PC of the EX instruction
//   BrTakenE       resolved direction
//   BrTargetE      resolved taken target
//   PredTakenE     prediction carried down the pipe with the branch
//   PredTargetE    predicted target carried down the pipe with the branch
//   MispredictE    EX branch mispredicted (flush request)
//   RecoverPCE     correct next PC for the EX branch
//   BranchCount    number of resolved branches
//   MissCount      number of mispredicted resolved branches
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        StallE,
    input  logic        BranchValidE,
    input  logic [31:0] PCE,
    input  logic        BrTakenE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RecoverPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MissCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Valid bits and counters are reset. Tags and targets are plain storage,
    // and they are only observed while their valid bit is set.
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [31:0]        r_branch_count;
    logic [31:0]        r_miss_count;

    // ---------------- fetch lookup ----------------
    logic [INDEX_BITS-1:0] w_fidx;
    logic [TAG_W-1:0]      w_ftag;
    logic                  w_fhit;

    assign w_fidx = PCF[INDEX_BITS+1:2];
    assign w_ftag = PCF[31:INDEX_BITS+2];
    assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);

    assign PredTakenF  = w_fhit && r_ctr[w_fidx][1];
    assign PredTargetF = PredTakenF ? r_target[w_fidx] : (PCF + 32'd4);

    // ---------------- execute resolution ----------------
    logic [INDEX_BITS-1:0] w_eidx;
    logic [TAG_W-1:0]      w_etag;
    logic                  w_ehit;
    logic                  w_upd;
    logic [1:0]            w_ctr_next;

    assign w_eidx = PCE[INDEX_BITS+1:2];
    assign w_etag = PCE[31:INDEX_BITS+2];
    assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
    assign w_upd  = BranchValidE && !StallE;

    // A target mismatch only counts when both the prediction and the outcome
    // are "taken". A not-taken branch does not care about its target field.
    assign MispredictE = BranchValidE &&
                         ((PredTakenE != BrTakenE) ||
                          (PredTakenE && BrTakenE && (PredTargetE != BrTargetE)));
    assign RecoverPCE  = BrTakenE ? BrTargetE : (PCE + 32'd4);

    // Saturating counter step for the entry being resolved.
    always_comb begin
        w_ctr_next = r_ctr[w_eidx];
        if (BrTakenE) begin
            if (r_ctr[w_eidx] != CTR_ST) begin
                w_ctr_next = r_ctr[w_eidx] + 2'd1;
            end
        end else begin
            if (r_ctr[w_eidx] != CTR_SNT) begin
                w_ctr_next = r_ctr[w_eidx] - 2'd1;
            end
        end
    end

    // Direction state. A hit updates the counter. A taken miss allocates the
    // entry at weakly-taken. A not-taken miss leaves the resident entry alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (w_upd) begin
            if (w_ehit) begin
                r_ctr[w_eidx] <= w_ctr_next;
            end else if (BrTakenE) begin
                r_valid[w_eidx] <= 1'b1;
                r_ctr[w_eidx]   <= CTR_WT;
            end
        end
    end

    // Tag and target storage. Every taken resolution writes here, on a hit or
    // on an allocation. On a hit the tag rewrite is a no-op. When an edge
    // coincides with reset, this write has no effect because the entry's
    // valid bit is held clear, so no partial entry ever becomes visible.
    always_ff @(posedge clk) begin
        if (w_upd && BrTakenE) begin
            r_tag[w_eidx]    <= w_etag;
            r_target[w_eidx] <= BrTargetE;
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count <= '0;
            r_miss_count   <= '0;
        end else if (w_upd) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (MispredictE) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign BranchCount = r_branch_count;
    assign MissCount   = r_miss_count;

    // Instructions are word aligned, so the two PC LSBs carry no information.
    logic w_unused_pc_lsbs;
    assign w_unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    localparam logic [1:0] CTR_WT_UNUSED_GUARD = CTR_WT;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed test of branch_predictor. A behavioural table model, indexed
//   by PC and holding integer counters, is compared with every DUT output on
//   each falling clock edge. Hand-computed literal checks pin the scenarios
//   that the model must also reproduce.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int IB = 6;
    localparam int N  = 1 << IB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PCF = 32'h0;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        StallE = 1'b0;
    logic        BranchValidE = 1'b0;
    logic [31:0] PCE = 32'h0;
    logic        BrTakenE = 1'b0;
    logic [31:0] BrTargetE = 32'h0;
    logic        PredTakenE = 1'b0;
    logic [31:0] PredTargetE = 32'h0;
    logic        MispredictE;
    logic [31:0] RecoverPCE;
    logic [31:0] BranchCount;
    logic [31:0] MissCount;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(IB)) dut (
        .clk(clk),
        .rst(rst),
        .PCF(PCF),
        .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF),
        .StallE(StallE),
        .BranchValidE(BranchValidE),
        .PCE(PCE),
        .BrTakenE(BrTakenE),
        .BrTargetE(BrTargetE),
        .PredTakenE(PredTakenE),
        .PredTargetE(PredTargetE),
        .MispredictE(MispredictE),
        .RecoverPCE(RecoverPCE),
        .BranchCount(BranchCount),
        .MissCount(MissCount)
    );

    // ---------------- behavioural model ----------------
    // Counter is an integer strength 0..3. Predict taken when strength >= 2.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int unsigned m_bc;
    int unsigned m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        return int'(w % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (IB + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispred();
        if (!BranchValidE) return 1'b0;
        if (PredTakenE != BrTakenE) return 1'b1;
        return BrTakenE && (PredTargetE != BrTargetE);
    endfunction

    function automatic logic [31:0] m_recover();
        return BrTakenE ? BrTargetE : PCE + 32'd4;
    endfunction

    int e_idx;
    assign e_idx = idx_of(PCE);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] <= 1'b0;
                m_ctr[i]   <= 1;
            end
            m_bc <= 0;
            m_mc <= 0;
        end else if (BranchValidE && !StallE) begin
            m_bc <= m_bc + 1;
            if (m_mispred()) m_mc <= m_mc + 1;
            if (m_hit(PCE)) begin
                if (BrTakenE) begin
                    m_ctr[e_idx] <= (m_ctr[e_idx] >= 3) ? 3 : m_ctr[e_idx] + 1;
                    m_tgt[e_idx] <= BrTargetE;
                end else begin
                    m_ctr[e_idx] <= (m_ctr[e_idx] <= 0) ? 0 : m_ctr[e_idx] - 1;
                end
            end else if (BrTakenE) begin
                m_valid[e_idx] <= 1'b1;
                m_tag[e_idx]   <= tag_of(PCE);
                m_tgt[e_idx]   <= BrTargetE;
                m_ctr[e_idx]   <= 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("PredTakenF",  {31'd0, PredTakenF}, {31'd0, m_taken(PCF)});
            chk("PredTargetF", PredTargetF, m_target(PCF));
            chk("MispredictE", {31'd0, MispredictE}, {31'd0, m_mispred()});
            chk("RecoverPCE",  RecoverPCE, m_recover());
            chk("BranchCount", BranchCount, m_bc);
            chk("MissCount",   MissCount, m_mc);
            $display("cycle t=%0t PCF=%h pred=%0b tgt=%h | E v=%0b st=%0b PCE=%h tk=%0b mis=%0b rec=%h | bc=%0d mc=%0d",
                     $time, PCF, PredTakenF, PredTargetF, BranchValidE, StallE, PCE,
                     BrTakenE, MispredictE, RecoverPCE, BranchCount, MissCount);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                          input bit ptaken, input logic [31:0] ptgt);
        PCE          = pc;
        BrTakenE     = taken;
        BrTargetE    = tgt;
        PredTakenE   = ptaken;
        PredTargetE  = ptgt;
        BranchValidE = 1'b1;
        cycle();
        BranchValidE = 1'b0;
    endtask

    bit walk_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit walk_p [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset asserted: lookups miss immediately.
        #1 rst = 1'b1;
        PCF = 32'h40;
        #1 started = 1'b1;
        chk("rst_pred",  {31'd0, PredTakenF}, 32'd0);
        chk("rst_tgt",   PredTargetF, 32'h44);
        chk("rst_bc",    BranchCount, 32'd0);
        chk("rst_mc",    MissCount, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_pred", {31'd0, PredTakenF}, 32'd0);
        chk("post_rst_tgt",  PredTargetF, 32'h44);
        chk("post_rst_bc",   BranchCount, 32'd0);

        // First taken branch on 0x40 is a mispredict and allocates an entry.
        PCE = 32'h40; BrTakenE = 1'b1; BrTargetE = 32'h10;
        PredTakenE = 1'b0; PredTargetE = 32'h44; BranchValidE = 1'b1;
        #1;
        chk("alloc_mis", {31'd0, MispredictE}, 32'd1);
        chk("alloc_rec", RecoverPCE, 32'h10);
        cycle();
        BranchValidE = 1'b0;
        chk("alloc_pred", {31'd0, PredTakenF}, 32'd1);
        chk("alloc_tgt",  PredTargetF, 32'h10);
        chk("alloc_bc",   BranchCount, 32'd1);
        chk("alloc_mc",   MissCount, 32'd1);

        // Counter walk from WT: N,N,N,T,T,T.
        for (int k = 0; k < 6; k++) begin
            branch(32'h40, walk_t[k], 32'h10, m_taken(32'h40), m_target(32'h40));
            chk($sformatf("walk%0d_pred", k), {31'd0, PredTakenF}, {31'd0, walk_p[k]});
        end
        chk("walk_bc", BranchCount, 32'd7);
        chk("walk_mc", MissCount, 32'd4);

        // Stalled update held three cycles, then released once.
        StallE = 1'b1;
        PCE = 32'h80; BrTakenE = 1'b0; BrTargetE = 32'h0;
        PredTakenE = 1'b0; PredTargetE = 32'h84; BranchValidE = 1'b1;
        cycle(); cycle(); cycle();
        chk("stall_hold_bc", BranchCount, 32'd7);
        StallE = 1'b0;
        cycle();
        BranchValidE = 1'b0;
        chk("stall_rel_bc", BranchCount, 32'd8);
        chk("stall_rel_mc", MissCount, 32'd4);

        // Direction right, target wrong: still a mispredict.
        PCE = 32'h40; BrTakenE = 1'b1; BrTargetE = 32'h10;
        PredTakenE = 1'b1; PredTargetE = 32'h20; BranchValidE = 1'b1;
        #1;
        chk("tgt_mis", {31'd0, MispredictE}, 32'd1);
        cycle();
        BranchValidE = 1'b0;

        // Recovery PC wraps at 2^32; not-taken miss does not allocate.
        PCE = 32'hFFFF_FFFC; BrTakenE = 1'b0; BrTargetE = 32'h0;
        PredTakenE = 1'b1; PredTargetE = 32'h1234; BranchValidE = 1'b1;
        #1;
        chk("wrap_rec", RecoverPCE, 32'h0);
        chk("wrap_mis", {31'd0, MispredictE}, 32'd1);
        cycle();
        BranchValidE = 1'b0;
        PCF = 32'hFFFF_FFFC;
        #1;
        chk("wrap_noalloc_pred", {31'd0, PredTakenF}, 32'd0);
        chk("wrap_noalloc_tgt",  PredTargetF, 32'h0);
        chk("wrap_bc", BranchCount, 32'd10);
        chk("wrap_mc", MissCount, 32'd6);

        // Alias: 0x140 shares the index of 0x40 and replaces it.
        PCF = 32'h40;
        branch(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
        chk("alias_old_pred", {31'd0, PredTakenF}, 32'd0);
        chk("alias_old_tgt",  PredTargetF, 32'h44);
        PCF = 32'h140;
        #1;
        chk("alias_new_pred", {31'd0, PredTakenF}, 32'd1);
        chk("alias_new_tgt",  PredTargetF, 32'h200);

        // Same-cycle lookup and allocation at 0x80.
        PCF = 32'h80;
        PCE = 32'h80; BrTakenE = 1'b1; BrTargetE = 32'h300;
        PredTakenE = 1'b0; PredTargetE = 32'h84; BranchValidE = 1'b1;
        #1;
        chk("same_pre_pred", {31'd0, PredTakenF}, 32'd0);
        cycle();
        BranchValidE = 1'b0;
        chk("same_post_pred", {31'd0, PredTakenF}, 32'd1);
        chk("same_post_tgt",  PredTargetF, 32'h300);
        chk("same_bc", BranchCount, 32'd12);
        chk("same_mc", MissCount, 32'd8);

        // Reset pulse mid-run, with a taken update pending across the edge.
        PCE = 32'h40; BrTakenE = 1'b1; BrTargetE = 32'h500;
        PredTakenE = 1'b0; PredTargetE = 32'h44; BranchValidE = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst2_pred", {31'd0, PredTakenF}, 32'd0);
        chk("rst2_tgt",  PredTargetF, 32'h84);
        chk("rst2_bc",   BranchCount, 32'd0);
        chk("rst2_mc",   MissCount, 32'd0);
        PCF = 32'h140;
        #1;
        chk("rst2_alias_pred", {31'd0, PredTakenF}, 32'd0);
        chk("rst2_alias_tgt",  PredTargetF, 32'h144);
        cycle();
        rst = 1'b0;
        BranchValidE = 1'b0;
        PCF = 32'h40;
        cycle();
        chk("rst2_discard_pred", {31'd0, PredTakenF}, 32'd0);
        chk("rst2_discard_bc",   BranchCount, 32'd0);

        cycle();
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: INDEX_BITS, default 6, log2 of table entries (64); index = PC[INDEX_BITS+1:2], tag = PC[31:INDEX_BITS+2].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 PCF  input  32  fetch PC for lookup.
REQ-005 PredTakenF  output  1  prediction for PCF: predicted taken.
REQ-006 PredTargetF  output  32  predicted target; equals PCF+4 when PredTakenF=0.
REQ-007 StallE  input  1  EX stage stalled; suppresses update and statistics.
REQ-008 BranchValidE  input  1  EX holds a conditional branch (BranchTypeE != none).
REQ-009 PCE  input  32  PC of the EX instruction.
REQ-010 BrTakenE  input  1  resolved outcome.
REQ-011 BrTargetE  input  32  resolved taken target (BrNPC).
REQ-012 PredTakenE, PredTargetE  input  1/32  prediction carried through the IF/ID/EX segment registers.
REQ-013 MispredictE  output  1  EX branch mispredicted; flush request to the hazard unit.
REQ-014 RecoverPCE  output  32  correct next PC when MispredictE=1.
REQ-015 BranchCount, MissCount  output  32 each  statistics counters.

Function
REQ-016 Table of 2^INDEX_BITS entries, each holding valid(1), tag, target(32) and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-017 Lookup is combinational, same cycle as PCF: hit = valid & tag match; PredTakenF = hit & counter[1]; PredTargetF = PredTakenF ? target : PCF+4.
REQ-018 Update occurs on the clock edge when BranchValidE=1 and StallE=0; no table change otherwise.
REQ-019 Hit update: counter saturating +1 if BrTakenE, -1 otherwise; ST+taken stays ST; SNT+not-taken stays SNT; target rewritten with BrTargetE when BrTakenE=1.
REQ-020 Miss update, taken: allocate (overwrite) the entry at index with valid=1, tag, target=BrTargetE, counter=WT.
REQ-021 Miss update, not-taken: no allocation; the existing entry is left untouched.
REQ-022 MispredictE (combinational) = BranchValidE & ((PredTakenE != BrTakenE) | (PredTakenE & BrTakenE & PredTargetE != BrTargetE)).
REQ-023 RecoverPCE = BrTakenE ? BrTargetE : PCE+4, 32-bit modulo arithmetic.
REQ-024 BranchCount +1 per qualifying update (REQ-018); MissCount +1 when the update also has MispredictE=1; both wrap at 2^32.
REQ-025 Lookup and update to the same index in one cycle: lookup returns the pre-edge contents; the new value is visible from the next cycle.
REQ-026 Aliasing: an entry whose tag mismatches is a miss; a taken branch replaces it per REQ-020.
REQ-027 MispredictE/RecoverPCE are valid regardless of StallE; the consumer qualifies them.

Reset
REQ-028 rst=1 clears all valid bits, sets all counters to WNT, and zeroes BranchCount and MissCount immediately, without waiting for a clock edge.
REQ-029 During reset and afterwards until allocation, PredTakenF=0 and PredTargetF=PCF+4.
REQ-030 Reset asserted mid-update discards that update; no partial entry write is permitted.
REQ-031 Target and tag fields need no reset value; outputs depend on them only when valid=1.

Verification
REQ-032 After reset, PCF=0x0000_0040 -> PredTakenF=0, PredTargetF=0x0000_0044, BranchCount=0.
REQ-033 Branch PCE=0x40, taken to 0x10, PredTakenE=0 -> MispredictE=1, RecoverPCE=0x10; next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x10, BranchCount=1, MissCount=1.
REQ-034 Counter walk on 0x40 from WT: outcomes N,N,N,T,T,T -> PredTakenF after each: 0,0,0,0,1,1 (WT->WNT->SNT->SNT->WNT->WT->ST).
REQ-035 Update with StallE=1 held 3 cycles, then released -> exactly one update and BranchCount +1.
REQ-036 Alias: entry for 0x40 allocated; taken branch at 0x40+(4<<INDEX_BITS)=0x140 -> entry replaced; lookup 0x40 -> PredTakenF=0.
REQ-037 Same-cycle lookup and allocation at 0x80 -> PredTakenF=0 that cycle, 1 the next; rst pulsed mid-run -> all lookups miss and counters read 0 before the next clock edge.
